// File: rtl/spi_slave.sv
// SPI mode-0 responder. The pins are synchronized to clk, and one word is exchanged per DATA_W sclk cycles.
// Reply words come through a 1-entry tx buffer. Each received word is reported with a single-cycle rx_valid pulse.
module spi_slave #(
  parameter int unsigned        DATA_W      = 8,
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  DEFAULT_TX  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, mosi_sr;
  logic                   sclk_d, cs_d;
  logic [DATA_W-1:0]      tx_sh, rx_sh, buf_data;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   reload;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall;
  logic do_load;
  logic [DATA_W-1:0] load_word;

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign cs_s      = cs_sr[SYNC_STAGES-1];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;

  // A load is taken either at frame start or on the falling edge after a completed word.
  assign do_load   = ((state == IDLE) && cs_fall) ||
                     ((state == SHIFT) && !cs_s && sclk_fall && reload);
  // tx_ready doubles as the buffer-empty flag.
  assign load_word = tx_ready ? DEFAULT_TX : buf_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sr     <= '0;
      cs_sr       <= '0;
      mosi_sr     <= '0;
      sclk_d      <= 1'b0;
      cs_d        <= 1'b0;
      state       <= IDLE;
      tx_sh       <= '0;
      rx_sh       <= '0;
      buf_data    <= '0;
      bit_cnt     <= '0;
      reload      <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      tx_ready    <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sclk_sr     <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      cs_sr       <= {cs_sr[SYNC_STAGES-2:0], cs};
      mosi_sr     <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      sclk_d      <= sclk_s;
      cs_d        <= cs_s;
      rx_valid    <= 1'b0;
      tx_underrun <= do_load & tx_ready;

      // Accept and load are exclusive, because a load only empties a full buffer.
      if (tx_valid && tx_ready) begin
        buf_data <= tx_data;
        tx_ready <= 1'b0;
      end else if (do_load && !tx_ready) begin
        tx_ready <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            miso_oe <= 1'b1;
            tx_sh   <= load_word;
            miso    <= load_word[DATA_W-1];
            bit_cnt <= '0;
            reload  <= 1'b0;
          end
        end
        SHIFT: begin
          if (cs_s) begin
            state   <= IDLE;
            busy    <= 1'b0;
            miso_oe <= 1'b0;
            miso    <= 1'b0;
            bit_cnt <= '0;
            reload  <= 1'b0;
          end else if (sclk_rise) begin
            rx_sh <= {rx_sh[DATA_W-2:0], mosi_s};
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              rx_data  <= {rx_sh[DATA_W-2:0], mosi_s};
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              reload   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (sclk_fall) begin
            if (reload) begin
              tx_sh  <= load_word;
              miso   <= load_word[DATA_W-1];
              reload <= 1'b0;
            end else begin
              tx_sh <= tx_sh << 1;
              miso  <= tx_sh[DATA_W-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave. Expected rx words are queued as frames are driven and popped by a monitor.
module tb_spi_slave;

  localparam int unsigned HALF = 40;

  logic       clk = 1'b0;
  logic       rst, sclk, cs, mosi, miso, miso_oe;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, tx_underrun, busy;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         rx_cnt   = 0;
  int         ur_cnt   = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx;

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2), .DEFAULT_TX(8'h00)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every rx_valid cycle pops one expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_underrun === 1'b1) ur_cnt++;
      if (rx_valid === 1'b1) begin
        rx_cnt++;
        if (rx_q.size() == 0) begin
          chk("rx_extra", 32'(rx_valid), 32'd0);
        end else begin
          exp_rx = rx_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(exp_rx));
        end
      end
    end
  end

  initial begin
    #200us;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "timeout");
  end

  task automatic cs_low();
    @(posedge clk); #1 cs = 1'b0;
    #(2*HALF);
  endtask

  task automatic cs_high();
    #HALF cs = 1'b1;
    #(2*HALF);
  endtask

  task automatic shift_bits(input logic [7:0] w, input int n, output logic [7:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      mosi = w[7-i];
      #HALF sclk = 1'b1;
      got = {got[6:0], miso};
      #HALF sclk = 1'b0;
    end
  endtask

  task automatic word(input logic [7:0] w, input logic [7:0] exp_miso, input string tag);
    logic [7:0] got;
    rx_q.push_back(w);
    shift_bits(w, 8, got);
    chk(tag, 32'(got), 32'(exp_miso));
  endtask

  task automatic push_tx(input logic [7:0] d);
    for (int i = 0; i < 50 && tx_ready !== 1'b1; i++) @(posedge clk);
    chk("push_ready", 32'(tx_ready), 32'd1);
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_miso"},     32'(miso),        32'd0);
    chk({tag, "_miso_oe"},  32'(miso_oe),     32'd0);
    chk({tag, "_tx_ready"}, 32'(tx_ready),    32'd1);
    chk({tag, "_rx_data"},  32'(rx_data),     32'd0);
    chk({tag, "_rx_valid"}, 32'(rx_valid),    32'd0);
    chk({tag, "_underrun"}, 32'(tx_underrun), 32'd0);
    chk({tag, "_busy"},     32'(busy),        32'd0);
  endtask

  initial begin
    int         u0, r0, ready_cycles;
    logic [7:0] got;
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(posedge clk); #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;

    // 1: preloaded reply
    push_tx(8'hA5);
    chk("t1_buf_full", 32'(tx_ready), 32'd0);
    u0 = ur_cnt; r0 = rx_cnt;
    cs_low();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_miso_oe", 32'(miso_oe), 32'd1);
    chk("t1_tx_ready", 32'(tx_ready), 32'd1);
    word(8'h3C, 8'hA5, "t1_miso");
    cs_high();
    chk("t1_rx_pulses", 32'(rx_cnt - r0), 32'd1);
    chk("t1_rx_data", 32'(rx_data), 32'h3C);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_oe_end", 32'(miso_oe), 32'd0);
    chk("t1_trailing_underrun", 32'(ur_cnt - u0), 32'd1);

    // 2: underrun at frame start
    u0 = ur_cnt;
    cs_low();
    chk("t2_underrun_at_load", 32'(ur_cnt - u0), 32'd1);
    word(8'hFF, 8'h00, "t2_miso");
    cs_high();
    chk("t2_rx_data", 32'(rx_data), 32'hFF);

    // 3: two words in one frame
    push_tx(8'hC3);
    r0 = rx_cnt;
    cs_low();
    push_tx(8'h5A);
    word(8'h12, 8'hC3, "t3_miso0");
    word(8'h34, 8'h5A, "t3_miso1");
    cs_high();
    chk("t3_rx_pulses", 32'(rx_cnt - r0), 32'd2);
    chk("t3_rx_data", 32'(rx_data), 32'h34);

    // 4: abort after five bits
    r0 = rx_cnt;
    cs_low();
    shift_bits(8'hA0, 5, got);
    cs_high();
    chk("t4_no_rx", 32'(rx_cnt - r0), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_oe", 32'(miso_oe), 32'd0);
    cs_low();
    word(8'h81, 8'h00, "t4_miso");
    cs_high();
    chk("t4_rx_data", 32'(rx_data), 32'h81);

    // 5: reset mid-frame
    cs_low();
    shift_bits(8'hF0, 3, got);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_reset_outputs("t5_rst");
    cs = 1'b1;
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("t5_idle_after_rst", 32'(busy), 32'd0);
    cs_low();
    word(8'h55, 8'h00, "t5_miso");
    cs_high();
    chk("t5_rx_data", 32'(rx_data), 32'h55);

    // 6: tx_valid held against a full buffer
    push_tx(8'h11);
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = 8'h22;
    repeat (4) @(posedge clk); #1;
    chk("t6_ready_held_low", 32'(tx_ready), 32'd0);
    cs = 1'b0;
    ready_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (tx_ready) ready_cycles++;
      else if (ready_cycles > 0) tx_valid = 1'b0;
    end
    tx_valid = 1'b0;
    chk("t6_ready_one_cycle", 32'(ready_cycles), 32'd1);
    chk("t6_refilled", 32'(tx_ready), 32'd0);
    word(8'hE7, 8'h11, "t6_miso0");
    word(8'h18, 8'h22, "t6_miso1");
    cs_high();
    chk("t6_rx_data", 32'(rx_data), 32'h18);

    chk("rx_queue_drained", 32'(rx_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
